// File: rtl/l2_tcdm_init_pkg.sv
// Shared types and helpers for the L2 TCDM init/self-test initiator.
// FSM state encoding, operation modes and TCDM write-enable encodings.
package l2_tcdm_init_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  localparam logic MODE_FILL  = 1'b0;
  localparam logic MODE_CHECK = 1'b1;

  localparam logic TCDM_WRITE = 1'b0;
  localparam logic TCDM_READ  = 1'b1;

  // Byte address of word idx relative to a word-aligned base, wrapping at 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/l2_tcdm_init_if.sv
// XBAR_TCDM_BUS-style request/response channel between an initiator and an L2 bank.
// req/gnt handshake on the request side, in-order r_valid responses.
interface l2_tcdm_init_if;
  logic        req;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        r_valid;
  logic [31:0] r_rdata;
  logic        r_opc;

  modport master (
    output req, add, wen, be, wdata,
    input  gnt, r_valid, r_rdata, r_opc
  );

  modport slave (
    input  req, add, wen, be, wdata,
    output gnt, r_valid, r_rdata, r_opc
  );
endinterface

// File: rtl/l2_tcdm_init_rsp_chk.sv
// Response checker: tracks in-order response index, compares against pattern + index,
// captures the byte address of the first mismatch (r_opc=1 always counts as a mismatch).
module l2_tcdm_init_rsp_chk
  import l2_tcdm_init_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        check_i,
  input  logic [31:0] base_i,
  input  logic [31:0] pattern_i,
  input  logic        r_valid_i,
  input  logic [31:0] r_rdata_i,
  input  logic        r_opc_i,
  output logic        err_o,
  output logic [31:0] err_addr_o
);

  localparam logic [LEN_WIDTH-1:0] IDX_ONE = LEN_WIDTH'(1);

  logic [LEN_WIDTH-1:0] rsp_idx_q;
  logic [31:0]          exp_data;
  logic                 mismatch;

  assign exp_data = pattern_i + 32'(rsp_idx_q);
  assign mismatch = r_opc_i || (check_i && (r_rdata_i != exp_data));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_idx_q  <= '0;
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else if (clr_i) begin
      rsp_idx_q  <= '0;
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else if (r_valid_i) begin
      rsp_idx_q <= rsp_idx_q + IDX_ONE;
      // Only the first failing word is reported; later ones keep the flag set.
      if (mismatch && !err_o) begin
        err_o      <= 1'b1;
        err_addr_o <= word_addr(base_i, 32'(rsp_idx_q));
      end
    end
  end

endmodule

// File: rtl/l2_tcdm_init_master.sv
// Fills (or with L2_TCDM_INIT_CHECK_EN, reads back and checks) a contiguous L2 region.
// req one cycle after start, up to MAX_OUTSTANDING in flight; request held stable until gnt.
module l2_tcdm_init_master
  import l2_tcdm_init_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned LEN_WIDTH       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [31:0]          addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic [31:0]          pattern_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [31:0]          err_addr_o,
  l2_tcdm_init_if.master       tcdm
);

  localparam int unsigned          OW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0]        MAX_OUT = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0]        OUT_ONE = OW'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_e               state_q, state_d;
  logic [31:0]          base_q, pat_q;
  logic [LEN_WIDTH-1:0] len_q, idx_q;
  logic [OW-1:0]        outst_q, outst_d;
  logic                 start_acc, req, gnt_hs, last_gnt, is_check;

  assign start_acc = start_i && (state_q == IDLE);
  assign req       = (state_q == ISSUE) && (idx_q < len_q) && (outst_q < MAX_OUT);
  assign gnt_hs    = req && tcdm.gnt;
  assign last_gnt  = gnt_hs && ((idx_q + LEN_ONE) == len_q);

  assign tcdm.req   = req;
  assign tcdm.add   = req ? word_addr(base_q, 32'(idx_q)) : '0;
  assign tcdm.wen   = (req && is_check) ? TCDM_READ : TCDM_WRITE;
  assign tcdm.be    = req ? 4'hF : 4'h0;
  assign tcdm.wdata = (req && !is_check) ? (pat_q + 32'(idx_q)) : '0;

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

  // A spurious r_valid with nothing outstanding must not underflow the counter.
  always_comb begin
    outst_d = outst_q;
    unique case ({gnt_hs, tcdm.r_valid})
      2'b10:   outst_d = outst_q + OUT_ONE;
      2'b01:   outst_d = (outst_q != '0) ? (outst_q - OUT_ONE) : '0;
      default: outst_d = outst_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = (len_i != '0) ? ISSUE : DONE;
      ISSUE:   if (last_gnt) state_d = DRAIN;
      DRAIN:   if (outst_d == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      base_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      if (start_acc) begin
        base_q <= {addr_i[31:2], 2'b00};
        len_q  <= len_i;
        pat_q  <= pattern_i;
        idx_q  <= '0;
      end else if (gnt_hs) begin
        idx_q <= idx_q + LEN_ONE;
      end
    end
  end

`ifdef L2_TCDM_INIT_CHECK_EN
  logic mode_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)        mode_q <= MODE_FILL;
    else if (start_acc) mode_q <= mode_i;
  end

  assign is_check = (mode_q == MODE_CHECK);

  l2_tcdm_init_rsp_chk #(
    .LEN_WIDTH (LEN_WIDTH)
  ) u_rsp_chk (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (start_acc),
    .check_i    (is_check),
    .base_i     (base_q),
    .pattern_i  (pat_q),
    .r_valid_i  (tcdm.r_valid),
    .r_rdata_i  (tcdm.r_rdata),
    .r_opc_i    (tcdm.r_opc),
    .err_o      (err_o),
    .err_addr_o (err_addr_o)
  );
`else
  // Fill-only build: mode and response payload are don't-care.
  logic unused_rsp;
  assign unused_rsp = ^{mode_i, tcdm.r_rdata, tcdm.r_opc};
  assign is_check   = (MODE_FILL == MODE_CHECK);
  assign err_o      = 1'b0;
  assign err_addr_o = '0;
`endif

  a_rvalid_outstanding: assert property (
    @(posedge clk_i) disable iff (!rst_ni) tcdm.r_valid |-> (outst_q != '0)
  );

endmodule
